riscv_hazard_forward_scoreboard: RTL and testbench
==================================================

// Module: riscv_hazard_forward_scoreboard
// PURPOSE
//  Next-generation forwarding/hazard block for the RISC-V pipeline. Generalises EX-operand
//  forwarding to NUM_SRC source operands and NUM_FWD producer stages.
//  Adds ID-stage load-use stall detection and an in-order scoreboard FIFO for long-latency
//  writers (mul/div, multi-cycle loads). Also provides a saturating stall-cycle counter.
//  Sits between decode (ID) and execute (EX) and drives operand muxes and the ID/IF stall.
// PARAMETERS
//  NUM_SRC      2   source operands checked per instruction (rs1, rs2, ...)
//  NUM_FWD      2   producer stages after EX; index 0 = youngest (MEM), NUM_FWD-1 = oldest (WB)
//  MAX_PENDING  4   long-latency scoreboard FIFO depth (power of 2, >=2)
//  SEL_W        $clog2(NUM_FWD+1)   forward-select width (derived, do not override)
//  CNT_W        32  stall-counter width
// PORTS
//  clk             in   1                 rising-edge clock
//  rst_n           in   1                 reset: synchronous, active-low
//  id_valid        in   1                 instruction valid in ID
//  id_rs_addr      in   NUM_SRC*5         ID sources; field i = [5i+4:5i]
//  ex_rs_addr      in   NUM_SRC*5         EX sources
//  ex_rd_addr      in   5                 EX destination
//  ex_reg_write    in   1                 EX writes rd
//  ex_is_load      in   1                 EX instruction is a single-cycle-latency load
//  fwd_rd_addr     in   NUM_FWD*5         per-stage destination
//  fwd_reg_write   in   NUM_FWD           per-stage write enable
//  fwd_data_ready  in   NUM_FWD           per-stage result available (0 = load still in MEM)
//  lt_issue        in   1                 long-latency op leaves EX this cycle
//  lt_rd_addr      in   5                 its destination
//  lt_done         in   1                 oldest long-latency op writes back this cycle
//  ex_fwd_sel      out  NUM_SRC*SEL_W     0 = regfile, k = fwd stage k-1
//  stall           out  1                 hold IF/ID and bubble EX
//  lt_full         out  1                 scoreboard full
//  lt_count        out  $clog2(MAX_PENDING)+1   occupied entries
//  lt_overflow     out  1                 sticky: issue while full without done
//  stall_cycles    out  CNT_W             saturating count of stall-asserted cycles
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): FIFO empty, lt_count=0, lt_full=0, lt_overflow=0,
//   stall_cycles=0; stall=0 and ex_fwd_sel=0 while reset is held.
//  Forwarding (combinational, 0 latency): per source i, sel = lowest k with
//   fwd_reg_write[k] & fwd_data_ready[k] & rd!=0 & rd==ex_rs[i], else 0.
//   A younger matching stage that is not ready blocks older stages (sel=0; stall covers it).
//   x0 sources always select 0.
//  Load-use: stall=1 if id_valid, ex_reg_write, ex_is_load, ex_rd_addr!=0, and it
//   matches any id_rs; one-cycle bubble; the next cycle clears via fwd_data_ready.
//  Scoreboard: FIFO of rd, in-order completion. Push on lt_issue (rd==0 not pushed).
//   Pop head on lt_done (ignored when empty).
//   Hazard if any valid entry != 0 matches any id_rs; the head is excluded when
//   lt_done=1 (WB forwarding covers it). Hazard -> stall=1.
//   stall=1 also when lt_full & ~lt_done & an ID instr would issue (id_valid).
//  Simultaneous push+pop: legal at any occupancy (including full); count unchanged.
//   Pointers wrap mod MAX_PENDING.
//  Push while full without pop: entry dropped, lt_overflow<=1 (sticky until reset).
//  stall_cycles += 1 every cycle stall=1; holds at 2^CNT_W-1.
//  Reset mid-operation discards all pending entries; the pipeline must be flushed with it.
//  Duplicate rd entries are legal; the hazard persists until all of them retire.
// TESTING
//  1 MEM rd=5 write ready, WB rd=5 write ready, ex_rs1=5 -> sel[0]=1 (MEM wins); rd=0 -> sel=0.
//  2 EX load rd=7, ID rs2=7 valid -> stall=1 one cycle, stall_cycles=1; next cycle MEM ready -> sel=1.
//  3 Issue div rd=9, ID rs1=9 -> stall held until lt_done cycle, where stall=0 and lt_count 1->0.
//  4 Issue 4 ops (MAX_PENDING=4) -> lt_full=1; 5th issue with done -> count stays 4, no overflow;
//    5th issue without done -> lt_overflow=1.
//  5 Wrap: 10 issue/done pairs interleaved -> heads retire in order; rd matches stay correct.
//  6 rst_n=0 with 3 pending and stall=1 -> next cycle lt_count=0, stall=0, stall_cycles=0.

Source files
------------

// File: rtl/riscv_hazard_forward_scoreboard.sv
// rtl/riscv_hazard_forward_scoreboard.sv - EX operand forwarding, load-use and long-latency scoreboard stall
module riscv_hazard_forward_scoreboard #(
  parameter int NUM_SRC     = 2,
  parameter int NUM_FWD     = 2,
  parameter int MAX_PENDING = 4,
  parameter int CNT_W       = 32,
  localparam int SEL_W      = $clog2(NUM_FWD + 1)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              id_valid,
  input  logic [NUM_SRC*5-1:0]              id_rs_addr,
  input  logic [NUM_SRC*5-1:0]              ex_rs_addr,
  input  logic [4:0]                        ex_rd_addr,
  input  logic                              ex_reg_write,
  input  logic                              ex_is_load,
  input  logic [NUM_FWD*5-1:0]              fwd_rd_addr,
  input  logic [NUM_FWD-1:0]                fwd_reg_write,
  input  logic [NUM_FWD-1:0]                fwd_data_ready,
  input  logic                              lt_issue,
  input  logic [4:0]                        lt_rd_addr,
  input  logic                              lt_done,
  output logic [NUM_SRC*SEL_W-1:0]          ex_fwd_sel,
  output logic                              stall,
  output logic                              lt_full,
  output logic [$clog2(MAX_PENDING):0]      lt_count,
  output logic                              lt_overflow,
  output logic [CNT_W-1:0]                  stall_cycles
);

  localparam int PW = $clog2(MAX_PENDING);
  localparam int CW = PW + 1;

  logic [4:0]               sb_q [MAX_PENDING];
  logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]            count_q, count_d;
  logic                     overflow_q, overflow_d;
  logic [CNT_W-1:0]         stall_cnt_q, stall_cnt_d;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel;
  logic                     push, pop, full, do_write;
  logic                     load_use, sb_hazard, stall_int;

  // Oldest-to-youngest scan so the youngest matching writer wins; a
  // not-yet-ready youngest match forces the regfile path and relies on stall.
  always_comb begin
    fwd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
        if (fwd_reg_write[k] && fwd_rd_addr[5*k +: 5] != 5'd0 &&
            fwd_rd_addr[5*k +: 5] == ex_rs_addr[5*i +: 5]) begin
          fwd_sel[SEL_W*i +: SEL_W] = fwd_data_ready[k] ? SEL_W'(k + 1) : '0;
        end
      end
    end
  end

  always_comb begin
    load_use = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_valid && ex_reg_write && ex_is_load && ex_rd_addr != 5'd0 &&
          id_rs_addr[5*i +: 5] == ex_rd_addr) begin
        load_use = 1'b1;
      end
    end
  end

  // The head retiring this cycle is covered by WB forwarding, so skip it.
  always_comb begin
    sb_hazard = 1'b0;
    for (int o = 0; o < MAX_PENDING; o++) begin
      if (CW'(o) < count_q && !(o == 0 && lt_done)) begin
        for (int i = 0; i < NUM_SRC; i++) begin
          if (sb_q[rd_ptr_q + PW'(o)] == id_rs_addr[5*i +: 5]) begin
            sb_hazard = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    full      = (count_q == CW'(MAX_PENDING));
    push      = lt_issue && (lt_rd_addr != 5'd0);
    pop       = lt_done && (count_q != '0);
    do_write  = push && (!full || pop);
    stall_int = load_use || sb_hazard || (full && !lt_done && id_valid);

    rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d   = do_write ? wr_ptr_q + PW'(1) : wr_ptr_q;
    count_d    = count_q;
    if (do_write && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!do_write && pop) begin
      count_d = count_q - CW'(1);
    end
    overflow_d  = overflow_q || (push && full && !pop);
    stall_cnt_d = (stall_int && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && do_write) begin
      sb_q[wr_ptr_q] <= lt_rd_addr;
    end
  end

  assign ex_fwd_sel   = rst_n ? fwd_sel : '0;
  assign stall        = rst_n && stall_int;
  assign lt_full      = full;
  assign lt_count     = count_q;
  assign lt_overflow  = overflow_q;
  assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_riscv_hazard_forward_scoreboard.sv
// tb/tb_riscv_hazard_forward_scoreboard.sv - directed scoreboard bench for the hazard/forward block
module tb_riscv_hazard_forward_scoreboard;

  localparam int NUM_SRC = 2, NUM_FWD = 2, MAX_PENDING = 4, CNT_W = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [9:0]  id_rs_addr, ex_rs_addr;
  logic [4:0]  ex_rd_addr;
  logic        ex_reg_write, ex_is_load;
  logic [9:0]  fwd_rd_addr;
  logic [1:0]  fwd_reg_write, fwd_data_ready;
  logic        lt_issue;
  logic [4:0]  lt_rd_addr;
  logic        lt_done;
  logic [3:0]  ex_fwd_sel;
  logic        stall, lt_full, lt_overflow;
  logic [2:0]  lt_count;
  logic [31:0] stall_cycles;

  always #5 clk = ~clk;

  riscv_hazard_forward_scoreboard #(
    .NUM_SRC(NUM_SRC), .NUM_FWD(NUM_FWD), .MAX_PENDING(MAX_PENDING), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs_addr(id_rs_addr),
    .ex_rs_addr(ex_rs_addr), .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write),
    .ex_is_load(ex_is_load), .fwd_rd_addr(fwd_rd_addr), .fwd_reg_write(fwd_reg_write),
    .fwd_data_ready(fwd_data_ready), .lt_issue(lt_issue), .lt_rd_addr(lt_rd_addr),
    .lt_done(lt_done), .ex_fwd_sel(ex_fwd_sel), .stall(stall), .lt_full(lt_full),
    .lt_count(lt_count), .lt_overflow(lt_overflow), .stall_cycles(stall_cycles)
  );

  typedef struct {
    int          sig;
    logic [31:0] val;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   sc_model = 0;

  function automatic logic [31:0] observe(int sig);
    case (sig)
      0:       return 32'(ex_fwd_sel);
      1:       return 32'(stall);
      2:       return 32'(lt_full);
      3:       return 32'(lt_count);
      4:       return 32'(lt_overflow);
      default: return stall_cycles;
    endcase
  endfunction

  task automatic exp_push(int sig, logic [31:0] v, string tag);
    exp_t e;
    e.sig = sig;
    e.val = v;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic settle();
    @(negedge clk);
    while (exp_q.size() > 0) begin
      exp_t        e;
      logic [31:0] o;
      e = exp_q.pop_front();
      o = observe(e.sig);
      tests++;
      assert (o === e.val) else begin
        fails++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, o, e.val);
      end
    end
  endtask

  task automatic step(string tag, logic e_stall, int e_cnt, logic e_full, logic e_ovf);
    exp_push(1, 32'(e_stall), {tag, ".stall"});
    exp_push(3, 32'(e_cnt), {tag, ".lt_count"});
    exp_push(2, 32'(e_full), {tag, ".lt_full"});
    exp_push(4, 32'(e_ovf), {tag, ".lt_overflow"});
    exp_push(5, 32'(sc_model), {tag, ".stall_cycles"});
    settle();
    @(posedge clk);
    if (!rst_n) sc_model = 0;
    else if (e_stall) sc_model++;
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs_addr = '0; ex_rs_addr = '0; ex_rd_addr = '0;
    ex_reg_write = 0; ex_is_load = 0; fwd_rd_addr = '0; fwd_reg_write = '0;
    fwd_data_ready = '0; lt_issue = 0; lt_rd_addr = '0; lt_done = 0;
  endtask

  initial begin
    rst_n = 0;
    idle();
    @(posedge clk); #1;

    // Outputs forced quiet while reset is held, even with hazards on the inputs
    fwd_rd_addr = {5'd5, 5'd5}; fwd_reg_write = 2'b11; fwd_data_ready = 2'b11;
    ex_rs_addr = {5'd0, 5'd5}; id_valid = 1; id_rs_addr = {5'd0, 5'd7};
    ex_reg_write = 1; ex_is_load = 1; ex_rd_addr = 5'd7;
    exp_push(0, 32'h0, "rst.sel");
    step("rst", 0, 0, 0, 0);
    rst_n = 1;
    idle();

    fwd_rd_addr = {5'd5, 5'd5}; fwd_reg_write = 2'b11; fwd_data_ready = 2'b11;
    ex_rs_addr = {5'd3, 5'd5};
    exp_push(0, 32'h1, "t1_mem_wins.sel");
    step("t1_mem_wins", 0, 0, 0, 0);
    fwd_reg_write = 2'b10;
    exp_push(0, 32'h2, "t1_wb_only.sel");
    step("t1_wb_only", 0, 0, 0, 0);
    fwd_reg_write = 2'b11; fwd_data_ready = 2'b10;
    exp_push(0, 32'h0, "t1_mem_not_ready.sel");
    step("t1_mem_not_ready", 0, 0, 0, 0);
    fwd_rd_addr = '0; ex_rs_addr = '0; fwd_data_ready = 2'b11;
    exp_push(0, 32'h0, "t1_x0.sel");
    step("t1_x0", 0, 0, 0, 0);
    fwd_rd_addr = {5'd6, 5'd4}; ex_rs_addr = {5'd6, 5'd4};
    exp_push(0, 32'h9, "t1_two_src.sel");
    step("t1_two_src", 0, 0, 0, 0);
    idle();

    id_valid = 1; id_rs_addr = {5'd7, 5'd1};
    ex_reg_write = 1; ex_is_load = 1; ex_rd_addr = 5'd7;
    step("t2_load_use", 1, 0, 0, 0);
    idle();
    fwd_rd_addr = {5'd0, 5'd7}; fwd_reg_write = 2'b01; fwd_data_ready = 2'b01;
    ex_rs_addr = {5'd7, 5'd1}; id_valid = 1;
    exp_push(0, 32'h4, "t2_fwd.sel");
    step("t2_fwd", 0, 0, 0, 0);
    idle();
    id_valid = 1; ex_reg_write = 1; ex_is_load = 1; ex_rd_addr = 5'd0;
    step("t2_x0_load", 0, 0, 0, 0);
    ex_is_load = 0; ex_rd_addr = 5'd7; id_rs_addr = {5'd7, 5'd0};
    step("t2_no_load", 0, 0, 0, 0);
    idle();

    lt_issue = 1; lt_rd_addr = 5'd9;
    step("t3_issue", 0, 0, 0, 0);
    idle();
    id_valid = 1; id_rs_addr = {5'd0, 5'd9};
    step("t3_wait1", 1, 1, 0, 0);
    step("t3_wait2", 1, 1, 0, 0);
    lt_done = 1;
    step("t3_done", 0, 1, 0, 0);
    lt_done = 0;
    step("t3_clear", 0, 0, 0, 0);
    idle();

    for (int r = 1; r <= 4; r++) begin
      lt_issue = 1; lt_rd_addr = 5'(r);
      step($sformatf("t4_fill%0d", r), 0, r - 1, 0, 0);
    end
    idle();
    step("t4_full", 0, 4, 1, 0);
    lt_issue = 1; lt_rd_addr = 5'd10; lt_done = 1;
    step("t4_push_pop", 0, 4, 1, 0);
    idle();
    step("t4_after_pp", 0, 4, 1, 0);
    lt_issue = 1; lt_rd_addr = 5'd11;
    step("t4_push_full", 0, 4, 1, 0);
    idle();
    id_valid = 1;
    step("t4_full_stall", 1, 4, 1, 1);
    lt_done = 1; id_rs_addr = {5'd0, 5'd2};
    step("t4_pop_head2", 0, 4, 1, 1);
    id_rs_addr = {5'd0, 5'd3};
    step("t4_pop_head3", 0, 3, 0, 1);
    id_rs_addr = {5'd0, 5'd10};
    step("t4_pop_10pending", 1, 2, 0, 1);
    step("t4_pop_head10", 0, 1, 0, 1);
    idle();
    lt_done = 1;
    step("t4_pop_empty", 0, 0, 0, 1);
    idle();
    step("t4_empty", 0, 0, 0, 1);

    lt_issue = 1; lt_rd_addr = 5'd20;
    step("t5_prime0", 0, 0, 0, 1);
    lt_rd_addr = 5'd21;
    step("t5_prime1", 0, 1, 0, 1);
    for (int n = 0; n < 10; n++) begin
      idle();
      id_valid = 1; id_rs_addr = {5'd0, 5'(20 + n)};
      step($sformatf("t5_pend%0d", n), 1, 2, 0, 1);
      lt_issue = 1; lt_rd_addr = 5'(22 + n); lt_done = 1;
      step($sformatf("t5_retire%0d", n), 0, 2, 0, 1);
    end
    idle();
    lt_done = 1;
    step("t5_drain0", 0, 2, 0, 1);
    step("t5_drain1", 0, 1, 0, 1);
    idle();
    step("t5_empty", 0, 0, 0, 1);

    lt_issue = 1; lt_rd_addr = 5'd12;
    step("t6_issue0", 0, 0, 0, 1);
    step("t6_issue1", 0, 1, 0, 1);
    lt_rd_addr = 5'd13;
    step("t6_issue2", 0, 2, 0, 1);
    lt_rd_addr = 5'd14; lt_done = 1; id_valid = 1; id_rs_addr = {5'd0, 5'd12};
    step("t6_dup", 1, 3, 0, 1);
    lt_issue = 0; lt_done = 0;
    step("t6_pending", 1, 3, 0, 1);
    rst_n = 0;
    step("t6_reset_held", 0, 3, 0, 1);
    rst_n = 1;
    step("t6_after_reset", 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
